quadrature_decoder: RTL
=======================

// Module: quadrature_decoder
// PURPOSE
//   Decodes a 2-phase quadrature encoder (qa/qb) into an N-bit up/down position count.
//   Feeds the up/down position count to downstream logic.
//   Inputs are asynchronous pins: synchronised, glitch-filtered, then decoded by a 4-state Gray FSM.
//   Illegal double-step transitions are flagged rather than counted.
// PARAMETERS
//   N           4  width of position count (wraps modulo 2^N)
//   SYNC_STAGES 2  synchroniser flops per input (>=2)
//   FILTER_LEN  3  consecutive equal synchronised samples required to accept a new qa/qb value (>=1)
// PORTS
//   clk     input   1  rising-edge clock
//   reset   input   1  asynchronous, active-high reset
//   enable  input   1  1: decoded steps update count; 0: FSM tracks phase, count frozen, no step
//   clear   input   1  synchronous: count<=0, err<=0
//   qa      input   1  encoder phase A (asynchronous)
//   qb      input   1  encoder phase B (asynchronous)
//   count   output  N  position count
//   dir     output  1  direction of last valid step: 1=up, 0=down
//   step    output  1  1-cycle pulse per counted step
//   wrap    output  1  1-cycle pulse when count wraps (max->0 up, 0->max down)
//   err     output  1  sticky: illegal transition seen since reset/clear
// BEHAVIOUR
//   Reset values: count=0, dir=1, step=0, wrap=0, err=0, FSM in INIT, filter history cleared.
//   Sync: qa and qb each pass through SYNC_STAGES flops.
//   Filter:
//     - filtered {a,b} takes the synchronised pair only after it has been identical for FILTER_LEN consecutive clocks.
//     - Shorter pulses are discarded.
//   FSM states: INIT, S00, S01, S11, S10 (named by filtered {a,b}).
//     - INIT -> state matching the first filtered value. No count change, no err.
//   Up sequence: S00->S01->S11->S10->S00 (B leads A).
//     - Each up transition: count+1, dir=1, step=1.
//   Down sequence: reverse order.
//     - Each down transition: count-1, dir=0, step=1.
//   Illegal transition (S00<->S11 or S01<->S10, both bits change at once):
//     - FSM moves to the new state.
//     - err<=1; count, dir unchanged; step=0.
//   No change in filtered value: no action.
//   Latency: a clean qa/qb edge held stable appears on count/step exactly SYNC_STAGES+FILTER_LEN+1 rising edges later (default 6).
//   Arithmetic is modulo 2^N:
//     - Up from 2^N-1 gives 0 with wrap=1.
//     - Down from 0 gives 2^N-1 with wrap=1.
//     - wrap coincides with step.
//   enable=0:
//     - FSM and filter keep running.
//     - count, dir, step, wrap held / low.
//     - err still sets on illegal transitions.
//   clear:
//     - Same-cycle step is discarded: count=0, err=0, step=0, wrap=0.
//     - clear has priority over enable and over an illegal transition.
//     - dir and FSM state are unaffected.
//   Reset mid-operation: all outputs return to reset values immediately; FSM re-enters INIT.
//   step and wrap are registered; at most one step per clock.
// TESTING
//   1. Reset with qa=qb=0, enable=1, apply 5 up steps 8 clocks apart -> count=5, dir=1, 5 step pulses, err=0.
//   2. From count=2, apply 3 down steps -> count=15 (N=4), wrap=1 on the 2->... step crossing 0, dir=0.
//   3. Up-step qa edge at cycle t -> step high exactly at t+6 (defaults).
//   4. 1- and 2-cycle glitches on qa -> no count change, no step, no err.
//   5. Drive qa,qb 00->11 in one cycle -> err=1 sticky, count unchanged.
//      Then clear -> err=0, count=0.
//   6. Release reset with qa=qb=1 -> INIT->S11, count=0, err=0.
//      Then enable=0 with 4 up steps -> count=0.
//      Then enable=1 with 1 up step -> count=1.
//   7. Assert reset mid-sequence at count=7 -> count=0 immediately.

Source files
------------

// File: rtl/quadrature_decoder_if.sv
// Encoder pins, control inputs and decoded position outputs of the quadrature decoder.
// master drives the encoder pins and controls; slave is the decoder itself.
interface quadrature_decoder_if #(
  parameter int N = 4
);
  logic         enable;
  logic         clear;
  logic         qa;
  logic         qb;
  logic [N-1:0] count;
  logic         dir;
  logic         step;
  logic         wrap;
  logic         err;

  modport master (output enable, clear, qa, qb, input count, dir, step, wrap, err);
  modport slave  (input enable, clear, qa, qb, output count, dir, step, wrap, err);
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronise qa/qb, glitch-filter the pair, and run a
// Gray-phase FSM that drives an up/down modulo-2^N position count.
module quadrature_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input logic                 clk,
  input logic                 reset,
  quadrature_decoder_if.slave bus
);
  // The filter window reuses the tail of the synchroniser chain as sample history.
  localparam int DEPTH = SYNC_STAGES + FILTER_LEN - 1;
  localparam int NEWEST = SYNC_STAGES - 1;

  typedef enum logic [2:0] {INIT, S00, S01, S11, S10} state_t;

  logic [DEPTH-1:0][1:0] chain_q, chain_d;
  logic [DEPTH-1:0]      vld_pipe_q, vld_pipe_d;
  logic [1:0]            filt_q, filt_d;
  logic                  filt_vld_q, filt_vld_d;
  logic                  win_ok;

  state_t                state_q, state_d, nxt;
  logic [N-1:0]          count_q, count_d;
  logic                  dir_q, dir_d;
  logic                  step_q, step_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
  logic [1:0]            delta;
  logic                  mv_up, mv_dn, bad;

  function automatic state_t to_state(input logic [1:0] ab);
    case (ab)
      2'b00:   return S00;
      2'b01:   return S01;
      2'b11:   return S11;
      default: return S10;
    endcase
  endfunction

  // Position along the up cycle S00->S01->S11->S10.
  function automatic logic [1:0] phase_idx(input state_t s);
    case (s)
      S01:     return 2'd1;
      S11:     return 2'd2;
      S10:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    chain_d    = {chain_q[DEPTH-2:0], {bus.qa, bus.qb}};
    vld_pipe_d = {vld_pipe_q[DEPTH-2:0], 1'b1};
    win_ok     = 1'b1;
    for (int i = NEWEST; i < DEPTH; i++)
      if (!vld_pipe_q[i] || chain_q[i] != chain_q[NEWEST]) win_ok = 1'b0;
    filt_d     = win_ok ? chain_q[NEWEST] : filt_q;
    filt_vld_d = filt_vld_q | win_ok;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err_q;
    mv_up   = 1'b0;
    mv_dn   = 1'b0;
    bad     = 1'b0;
    nxt     = to_state(filt_q);
    delta   = phase_idx(nxt) - phase_idx(state_q);
    if (filt_vld_q) begin
      if (state_q == INIT) begin
        state_d = nxt;
      end else if (nxt != state_q) begin
        state_d = nxt;
        case (delta)
          2'd1:    mv_up = 1'b1;
          2'd3:    mv_dn = 1'b1;
          default: bad   = 1'b1;
        endcase
      end
    end
    if (bad) err_d = 1'b1;
    if (bus.enable && mv_up) begin
      count_d = count_q + N'(1);
      dir_d   = 1'b1;
      step_d  = 1'b1;
      wrap_d  = &count_q;
    end
    if (bus.enable && mv_dn) begin
      count_d = count_q - N'(1);
      dir_d   = 1'b0;
      step_d  = 1'b1;
      wrap_d  = ~|count_q;
    end
    // Clear wins over a same-cycle step or illegal transition; dir and phase persist.
    if (bus.clear) begin
      count_d = '0;
      err_d   = 1'b0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q    <= '0;
      vld_pipe_q <= '0;
      filt_q     <= 2'b00;
      filt_vld_q <= 1'b0;
      state_q    <= INIT;
      count_q    <= '0;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      vld_pipe_q <= vld_pipe_d;
      filt_q     <= filt_d;
      filt_vld_q <= filt_vld_d;
      state_q    <= state_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule
